// File: rtl/gate_seq_pkg.sv
// Shared state encoding, row count and sizing helpers for the gate truth-table driver.
package gate_seq_pkg;

  localparam int unsigned NUM_ROWS = 4;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDrive  = 3'd1,
    StSample = 3'd2,
    StHold   = 3'd3,
    StDone   = 3'd4
  } gate_seq_state_e;

  function automatic int unsigned calc_step_cycles(input int unsigned clk_hz,
                                                   input int unsigned step_hz);
    return clk_hz / step_hz;
  endfunction

  function automatic int unsigned calc_cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/input_sync_edge.sv
// Two-flop synchronizer; rising-edge pulse is derived from registered stages only.
module input_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/gate_truth_table_driver.sv
// Walks a two-input gate through rows 00..11 and checks its output against TRUTH_TABLE.
// Define GATE_SEQ_MANUAL_STEP_EN to advance rows with a debounced I_P_STEP button.
module gate_truth_table_driver
  import gate_seq_pkg::*;
#(
  parameter int unsigned          CLK_HZ          = 100_000_000,
  parameter int unsigned          STEP_HZ         = 1,
  parameter logic [NUM_ROWS-1:0]  TRUTH_TABLE     = 4'b1000,
  parameter int unsigned          SETTLE_CYCLES   = 4,
  parameter int unsigned          DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                I_P_CLK,
  input  logic                I_P_RST,
  input  logic                I_P_START,
  input  logic                I_P_GATE_Y,
`ifdef GATE_SEQ_MANUAL_STEP_EN
  input  logic                I_P_STEP,
`endif
  output logic                O_P_A,
  output logic                O_P_B,
  output logic                O_P_LED_A,
  output logic                O_P_LED_B,
  output logic                O_P_LED_BUSY,
  output logic                O_P_LED_PASS,
  output logic                O_P_LED_FAIL,
  output logic [NUM_ROWS-1:0] O_P_LED_ERR
);

  localparam int unsigned STEP_CYCLES = calc_step_cycles(CLK_HZ, STEP_HZ);
`ifdef GATE_SEQ_MANUAL_STEP_EN
  localparam int unsigned CntMax = SETTLE_CYCLES + 1;
`else
  localparam int unsigned CntMax = STEP_CYCLES - 1;
`endif
  localparam int unsigned CntW = calc_cnt_width(CntMax + 1);

  if (SETTLE_CYCLES < 3) begin : g_settle_chk
    $error("SETTLE_CYCLES must be at least 3");
  end
  if (STEP_HZ == 0 || DEBOUNCE_CYCLES == 0) begin : g_rate_chk
    $error("STEP_HZ and DEBOUNCE_CYCLES must be non-zero");
  end
`ifndef GATE_SEQ_MANUAL_STEP_EN
  if (STEP_CYCLES < SETTLE_CYCLES + 2) begin : g_step_chk
    $error("STEP_CYCLES must be at least SETTLE_CYCLES + 2");
  end
`endif

  gate_seq_state_e     state_q, state_d;
  logic [1:0]          row_q, row_d;
  logic [1:0]          ab_q, ab_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NUM_ROWS-1:0] err_q, err_d;
  logic                start_rise, sync_y, hold_exit;
  logic                unused_start_level, unused_y_rise;

  input_sync_edge u_sync_start (
    .clk_i  (I_P_CLK),
    .rst_i  (I_P_RST),
    .d_i    (I_P_START),
    .level_o(unused_start_level),
    .rise_o (start_rise)
  );

  input_sync_edge u_sync_y (
    .clk_i  (I_P_CLK),
    .rst_i  (I_P_RST),
    .d_i    (I_P_GATE_Y),
    .level_o(sync_y),
    .rise_o (unused_y_rise)
  );

`ifdef GATE_SEQ_MANUAL_STEP_EN
  localparam int unsigned DbW = calc_cnt_width(DEBOUNCE_CYCLES);

  logic           step_level, unused_step_rise, step_rise;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           db_stable_q, db_stable_d;
  logic           step_pending_q, step_pending_d;

  input_sync_edge u_sync_step (
    .clk_i  (I_P_CLK),
    .rst_i  (I_P_RST),
    .d_i    (I_P_STEP),
    .level_o(step_level),
    .rise_o (unused_step_rise)
  );

  // The stable level only follows the input after DEBOUNCE_CYCLES consecutive differing cycles.
  always_comb begin
    db_cnt_d    = db_cnt_q;
    db_stable_d = db_stable_q;
    if (step_level == db_stable_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
      db_stable_d = step_level;
      db_cnt_d    = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign step_rise = db_stable_d & ~db_stable_q;
  assign hold_exit = step_pending_q | step_rise;

  always_comb begin
    step_pending_d = step_pending_q;
    if (state_q == StDrive || state_q == StSample) begin
      if (step_rise) step_pending_d = 1'b1;
    end else if (state_q == StHold) begin
      if (hold_exit) step_pending_d = 1'b0;
    end else begin
      step_pending_d = 1'b0;
    end
  end

  always_ff @(posedge I_P_CLK or posedge I_P_RST) begin
    if (I_P_RST) begin
      db_cnt_q       <= '0;
      db_stable_q    <= 1'b0;
      step_pending_q <= 1'b0;
    end else begin
      db_cnt_q       <= db_cnt_d;
      db_stable_q    <= db_stable_d;
      step_pending_q <= step_pending_d;
    end
  end
`else
  assign hold_exit = (cnt_q == CntW'(STEP_CYCLES - 1));
`endif

  // cnt_q restarts at every DRIVE entry so the row period is measured from A/B update.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    ab_d    = ab_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_rise) begin
          err_d   = '0;
          row_d   = '0;
          ab_d    = '0;
          cnt_d   = '0;
          state_d = StDrive;
        end
      end
      StDrive: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(SETTLE_CYCLES - 1)) state_d = StSample;
      end
      StSample: begin
        cnt_d        = cnt_q + 1'b1;
        err_d[row_q] = sync_y ^ TRUTH_TABLE[row_q];
        state_d      = StHold;
      end
      StHold: begin
        if (hold_exit) begin
          cnt_d = '0;
          if (row_q == 2'(NUM_ROWS - 1)) begin
            state_d = StDone;
          end else begin
            row_d   = row_q + 2'd1;
            ab_d    = row_q + 2'd1;
            state_d = StDrive;
          end
        end
`ifndef GATE_SEQ_MANUAL_STEP_EN
        else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge I_P_CLK or posedge I_P_RST) begin
    if (I_P_RST) begin
      state_q <= StIdle;
      row_q   <= '0;
      ab_q    <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      ab_q    <= ab_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign O_P_A        = ab_q[1];
  assign O_P_B        = ab_q[0];
  assign O_P_LED_A    = ab_q[1];
  assign O_P_LED_B    = ab_q[0];
  assign O_P_LED_BUSY = (state_q == StDrive) || (state_q == StSample) || (state_q == StHold);
  assign O_P_LED_PASS = (state_q == StDone) && (err_q == '0);
  assign O_P_LED_FAIL = (state_q == StDone) && (err_q != '0);
  assign O_P_LED_ERR  = err_q;

endmodule
